// File: rtl/signed_or_unsigned_mul_seq.sv
// Sequential shift-add multiplier for signed or unsigned operands.
// One n-bit adder is reused for n iterations per product.
module signed_or_unsigned_mul_seq #(
    parameter int n = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [n-1:0]     a,
    input  logic [n-1:0]     b,
    input  logic             signed_mul,
    output logic             down_valid,
    input  logic             down_ready,
    output logic [2*n-1:0]   res
);

    localparam int CW = $clog2(n);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Visible to checkers through the hierarchy as u_dut.state.
    state_t state;
    state_t state_next;

    logic [n-1:0]   mag_a;
    logic [n-1:0]   mag_b;
    logic           neg;
    logic [2*n-1:0] acc;
    logic [CW-1:0]  cnt;

    logic           accept;
    logic           consume;
    logic           last_iter;
    logic [n-1:0]   a_mag_in;
    logic [n-1:0]   b_mag_in;
    logic [n-1:0]   addend;
    logic [n:0]     sum;
    logic [2*n-1:0] acc_next;
    logic [2*n-1:0] product;

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // ready depends only on state, and valid/data are held by the producer
    // until that edge.
    assign up_ready   = (state == IDLE);
    assign down_valid = (state == DONE);
    assign accept     = up_valid && up_ready;
    assign consume    = down_valid && down_ready;
    assign last_iter  = (cnt == CW'(n - 1));

    // The most negative operand negates to 2^(n-1), which still fits unsigned.
    assign a_mag_in = (signed_mul && a[n-1]) ? (~a + n'(1)) : a;
    assign b_mag_in = (signed_mul && b[n-1]) ? (~b + n'(1)) : b;

    assign addend   = mag_b[0] ? mag_a : '0;
    assign sum      = {1'b0, acc[2*n-1:n]} + {1'b0, addend};
    assign acc_next = {sum, acc[n-1:1]};
    assign product  = neg ? (~acc_next + (2*n)'(1)) : acc_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (accept) state_next = BUSY;
            BUSY: if (last_iter) state_next = DONE;
            DONE: if (consume) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag_a <= '0;
            mag_b <= '0;
            neg   <= 1'b0;
            acc   <= '0;
            cnt   <= '0;
            res   <= '0;
        end else begin
            if (accept) begin
                mag_a <= a_mag_in;
                mag_b <= b_mag_in;
                neg   <= signed_mul && (a[n-1] ^ b[n-1]);
                acc   <= '0;
                cnt   <= '0;
            end else if (state == BUSY) begin
                acc   <= acc_next;
                mag_b <= mag_b >> 1;
                cnt   <= cnt + CW'(1);
                if (last_iter) begin
                    res <= product;
                end
            end
        end
    end

endmodule
